// File: rtl/m_seq.sv
// ---------------------------------------------------------------------------
// m_seq : sequencer and R/D/Z state registers of the M-extension unit.
//
// Takes one MUL/DIV-class request at a time and steers the external
// combinational M datapath through its mux selects. Multiplies finish after a
// single MUL cycle. Divides run a 32-step restoring iteration and then one
// FIX cycle that applies the sign. Each result is held in DONE until the
// consumer takes it.
//
// Ports
//   clk, resetn              clock (rising edge), async active-low reset
//   in_valid / in_ready      request handshake; in_ready only in IDLE
//   op, rs1, rs2             funct3 and the two operands
//   out_valid / out_ready    result handshake
//   result                   32-bit result, changes only on entry to DONE
//   mux_multA, mux_multB     multiplier operand selects (ZERO/UNSIGNED/SIGNED)
//   mux_div_rem              quotient/remainder select for the sign fix-up
//   R, D, Z                  remainder, shifted divisor, quotient registers
//   sub_result, product,     datapath returns: R - D[31:0], A*B,
//   div_rem, div_rem_neg     selected Z/R and its two's complement
//
// Configuration macro: M_DIV_EARLY_OUT_EN
//   When defined, a divide whose divisor is zero, or whose |dividend| is below
//   its |divisor|, finishes at accept and goes directly to DONE.
//
// The select widths and encodings normally come from m_definitions.svh. The
// guarded defaults below keep this file self-contained when that header is
// not in the build.
// ---------------------------------------------------------------------------
`ifndef MUX_MULTA_LENGTH
`define MUX_MULTA_LENGTH 2
`endif
`ifndef MUX_MULTB_LENGTH
`define MUX_MULTB_LENGTH 2
`endif
`ifndef MUX_DIV_REM_LENGTH
`define MUX_DIV_REM_LENGTH 1
`endif
`ifndef MUX_MULT_ZERO
`define MUX_MULT_ZERO 2'd0
`endif
`ifndef MUX_MULT_UNSIGNED
`define MUX_MULT_UNSIGNED 2'd1
`endif
`ifndef MUX_MULT_SIGNED
`define MUX_MULT_SIGNED 2'd2
`endif
`ifndef MUX_DIV_REM_R
`define MUX_DIV_REM_R 1'b0
`endif
`ifndef MUX_DIV_REM_Z
`define MUX_DIV_REM_Z 1'b1
`endif

module m_seq (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [2:0]                     op,
    input  logic [31:0]                    rs1,
    input  logic [31:0]                    rs2,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    result,
    output logic [`MUX_MULTA_LENGTH-1:0]   mux_multA,
    output logic [`MUX_MULTB_LENGTH-1:0]   mux_multB,
    output logic [`MUX_DIV_REM_LENGTH-1:0] mux_div_rem,
    output logic [31:0]                    R,
    output logic [62:0]                    D,
    output logic [31:0]                    Z,
    input  logic [31:0]                    sub_result,
    input  logic [63:0]                    product,
    input  logic [31:0]                    div_rem,
    input  logic [31:0]                    div_rem_neg
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [1:0]  op_q;
    logic        rs1_neg;
    logic        rs2_neg;
    logic        rs2_zero;
    logic [4:0]  count;

    logic        accept;
    logic        is_div_op;
    logic        div_signed;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic        fit;
    logic        early;
    logic        neg_q;
    logic        neg_r;
    logic        fix_neg;

    assign accept     = in_valid && in_ready;
    assign is_div_op  = op[2];
    // DIV (4) and REM (6) are the signed divides; odd codes are unsigned.
    assign div_signed = ~op[0];
    assign abs1       = (div_signed && rs1[31]) ? -rs1 : rs1;
    assign abs2       = (div_signed && rs2[31]) ? -rs2 : rs2;

    // Divisor still has bits above the 32-bit window, so it cannot fit yet.
    assign fit = (D[62:32] == 31'd0) && (R >= D[31:0]);

    // A zero divisor keeps the quotient positive, which turns the all-ones
    // quotient into the expected 0xFFFFFFFF for signed divides too.
    assign neg_q   = ~op_q[0] && (rs1_neg != rs2_neg) && !rs2_zero;
    assign neg_r   = ~op_q[0] && rs1_neg;
    assign fix_neg = op_q[1] ? neg_r : neg_q;

`ifdef M_DIV_EARLY_OUT_EN
    logic [31:0] early_result;
    assign early        = is_div_op && ((abs2 == 32'd0) || (abs1 < abs2));
    // Both early cases leave the remainder equal to the raw dividend; the
    // quotient is all ones for a zero divisor and zero otherwise.
    assign early_result = op[1] ? rs1 : ((abs2 == 32'd0) ? 32'hFFFF_FFFF : 32'd0);
`else
    assign early = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and the handshake/select outputs decoded from state.
    always_comb begin
        state_nx    = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        mux_multA   = `MUX_MULT_ZERO;
        mux_multB   = `MUX_MULT_ZERO;
        mux_div_rem = `MUX_DIV_REM_R;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (!is_div_op) begin
                        state_nx = ST_MUL;
                    end else if (early) begin
                        state_nx = ST_DONE;
                    end else begin
                        state_nx = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                mux_multA = (op_q == 2'd1 || op_q == 2'd2) ? `MUX_MULT_SIGNED : `MUX_MULT_UNSIGNED;
                mux_multB = (op_q == 2'd1) ? `MUX_MULT_SIGNED : `MUX_MULT_UNSIGNED;
                state_nx  = ST_DONE;
            end
            ST_DIV: begin
                if (count == 5'd0) begin
                    state_nx = ST_FIX;
                end
            end
            ST_FIX: begin
                mux_div_rem = op_q[1] ? `MUX_DIV_REM_R : `MUX_DIV_REM_Z;
                state_nx    = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Operand/state registers and the result register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            R        <= 32'd0;
            D        <= 63'd0;
            Z        <= 32'd0;
            result   <= 32'd0;
            count    <= 5'd0;
            op_q     <= 2'd0;
            rs1_neg  <= 1'b0;
            rs2_neg  <= 1'b0;
            rs2_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q     <= op[1:0];
                        rs1_neg  <= rs1[31];
                        rs2_neg  <= rs2[31];
                        rs2_zero <= (rs2 == 32'd0);
                        if (!is_div_op) begin
                            R <= rs1;
                            D <= {rs2, 31'd0};
                        end else begin
                            R     <= abs1;
                            D     <= {abs2, 31'd0};
                            Z     <= 32'd0;
                            count <= 5'd31;
`ifdef M_DIV_EARLY_OUT_EN
                            if (early) begin
                                result <= early_result;
                            end
`endif
                        end
                    end
                end
                ST_MUL: begin
                    result <= (op_q == 2'd0) ? product[31:0] : product[63:32];
                end
                ST_DIV: begin
                    if (fit) begin
                        R <= sub_result;
                    end
                    Z <= {Z[30:0], fit};
                    D <= D >> 1;
                    if (count != 5'd0) begin
                        count <= count - 5'd1;
                    end
                end
                ST_FIX: begin
                    result <= fix_neg ? div_rem_neg : div_rem;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_seq.sv
// ---------------------------------------------------------------------------
// tb_m_seq : self-checking bench for m_seq.
//
// Models the combinational M datapath around the sequencer. A reference
// model derives each operation's result and latency from plain arithmetic,
// and a compare process checks every output on every falling edge. Directed
// stimulus carries hand-computed results and latencies as well.
// Honours M_DIV_EARLY_OUT_EN in the same way as the design.
// ---------------------------------------------------------------------------
`ifndef MUX_MULTA_LENGTH
`define MUX_MULTA_LENGTH 2
`endif
`ifndef MUX_MULTB_LENGTH
`define MUX_MULTB_LENGTH 2
`endif
`ifndef MUX_DIV_REM_LENGTH
`define MUX_DIV_REM_LENGTH 1
`endif

module tb_m_seq;

    localparam logic [1:0] MZERO  = 2'd0;
    localparam logic [1:0] MUNS   = 2'd1;
    localparam logic [1:0] MSIGN  = 2'd2;
    localparam logic       DR_R   = 1'b0;
    localparam logic       DR_Z   = 1'b1;
`ifdef M_DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 34;
`endif

    logic                           clk;
    logic                           resetn;
    logic                           in_valid;
    logic                           in_ready;
    logic [2:0]                     op;
    logic [31:0]                    rs1;
    logic [31:0]                    rs2;
    logic                           out_valid;
    logic                           out_ready;
    logic [31:0]                    result;
    logic [`MUX_MULTA_LENGTH-1:0]   mux_multA;
    logic [`MUX_MULTB_LENGTH-1:0]   mux_multB;
    logic [`MUX_DIV_REM_LENGTH-1:0] mux_div_rem;
    logic [31:0]                    R;
    logic [62:0]                    D;
    logic [31:0]                    Z;
    logic [31:0]                    sub_result;
    logic [63:0]                    product;
    logic [31:0]                    div_rem;
    logic [31:0]                    div_rem_neg;

    int checks = 0;
    int errors = 0;

    m_seq dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .rs1         (rs1),
        .rs2         (rs2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .mux_multA   (mux_multA),
        .mux_multB   (mux_multB),
        .mux_div_rem (mux_div_rem),
        .R           (R),
        .D           (D),
        .Z           (Z),
        .sub_result  (sub_result),
        .product     (product),
        .div_rem     (div_rem),
        .div_rem_neg (div_rem_neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational M datapath as seen by the sequencer.
    logic signed [63:0] pa;
    logic signed [63:0] pb;
    logic [31:0]        dhi;
    always_comb begin
        dhi = D[62:31];
        pa  = '0;
        pb  = '0;
        case (mux_multA)
            MUNS:    pa = {32'd0, R};
            MSIGN:   pa = {{32{R[31]}}, R};
            default: pa = '0;
        endcase
        case (mux_multB)
            MUNS:    pb = {32'd0, dhi};
            MSIGN:   pb = {{32{dhi[31]}}, dhi};
            default: pb = '0;
        endcase
        product     = pa * pb;
        sub_result  = R - D[31:0];
        div_rem     = (mux_div_rem == DR_Z) ? Z : R;
        div_rem_neg = -div_rem;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from the RISC-V M-extension arithmetic rules.
    function automatic logic [31:0] modelResult(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint     sa;
        longint     sb;
        longint     ub;
        logic [63:0] p;
        int         ia;
        int         ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        p  = '0;
        case (o)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    // Edges from accept until out_valid is seen.
    function automatic int modelLatency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint ma;
        longint mb;
        if (!o[2]) return 2;
        ma = o[0] ? longint'({32'd0, a}) : longint'($signed(a));
        mb = o[0] ? longint'({32'd0, b}) : longint'($signed(b));
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef M_DIV_EARLY_OUT_EN
        if (mb == 0 || ma < mb) return 1;
`endif
        return 34;
    endfunction

    // Model state for the compare process.
    bit          outstanding = 1'b0;
    int          k = 0;
    int          cur_lat = 0;
    logic [2:0]  cur_op = '0;
    logic [31:0] cur_exp = '0;
    logic [31:0] prev_result = '0;

    // Every falling edge: compare all outputs against the model, then
    // advance the model for the coming rising edge.
    always @(negedge clk) begin
        logic       exp_valid;
        logic [1:0] exp_ma;
        logic [1:0] exp_mb;
        logic       exp_dr;
        if (!resetn) begin
            outstanding = 1'b0;
            prev_result = '0;
            checkOutput("rst_in_ready", in_ready, 1);
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_result", result, 0);
            checkOutput("rst_R", R, 0);
            checkOutput("rst_D", D, 0);
            checkOutput("rst_Z", Z, 0);
            checkOutput("rst_multA", mux_multA, MZERO);
            checkOutput("rst_multB", mux_multB, MZERO);
            checkOutput("rst_div_rem", mux_div_rem, DR_R);
        end else begin
            exp_valid = outstanding && (k >= cur_lat - 1);
            exp_ma    = MZERO;
            exp_mb    = MZERO;
            exp_dr    = DR_R;
            if (outstanding && !cur_op[2] && k == 0) begin
                exp_ma = (cur_op == 3'd1 || cur_op == 3'd2) ? MSIGN : MUNS;
                exp_mb = (cur_op == 3'd1) ? MSIGN : MUNS;
            end
            if (outstanding && cur_op[2] && cur_lat == 34 && k == 32) begin
                exp_dr = cur_op[1] ? DR_R : DR_Z;
            end
            checkOutput("in_ready", in_ready, !outstanding);
            checkOutput("out_valid", out_valid, exp_valid);
            checkOutput("result", result, exp_valid ? cur_exp : prev_result);
            checkOutput("mux_multA", mux_multA, exp_ma);
            checkOutput("mux_multB", mux_multB, exp_mb);
            checkOutput("mux_div_rem", mux_div_rem, exp_dr);
            if (outstanding) begin
                if (exp_valid && out_ready) begin
                    outstanding = 1'b0;
                    prev_result = cur_exp;
                end else begin
                    k++;
                end
            end else if (in_valid) begin
                outstanding = 1'b1;
                k           = 0;
                cur_op      = op;
                cur_lat     = modelLatency(op, rs1, rs2);
                cur_exp     = modelResult(op, rs1, rs2);
            end
        end
    end

    // One full operation with hand-computed result and latency; out_ready is
    // held low for 'hold' cycles once the result shows up.
    task automatic applyStimulus(input string name, input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input int hold,
                                 input logic [31:0] exp_lit, input int lat_lit);
        int cyc;
        bit got;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        op       = o;
        rs1      = a;
        rs2      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            if (out_valid) got = 1'b1;
            else cyc++;
        end
        checkOutput({name, "_latency"}, got ? cyc + 1 : 0, lat_lit);
        checkOutput({name, "_result"}, result, exp_lit);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({name, "_hold_valid"}, out_valid, 1);
            checkOutput({name, "_hold_result"}, result, exp_lit);
            checkOutput({name, "_hold_busy"}, in_ready, 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput({name, "_idle"}, in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int spurious;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = '0;
        rs1       = '0;
        rs2       = '0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_ready", in_ready, 1);
        checkOutput("post_reset_valid", out_valid, 0);
        checkOutput("post_reset_result", result, 0);

        applyStimulus("mulhsu",     3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 0, 32'hFFFF_FFFF, 2);
        applyStimulus("mul",        3'd0, 32'h1234_5678, 32'h0000_0010, 0, 32'h2345_6780, 2);
        applyStimulus("mulh",       3'd1, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000, 2);
        applyStimulus("mulhu",      3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 2);
        applyStimulus("div_neg",    3'd4, 32'hFFFF_FFF9, 32'd2,         0, 32'hFFFF_FFFD, 34);
        applyStimulus("rem_neg",    3'd6, 32'hFFFF_FFF9, 32'd2,         0, 32'hFFFF_FFFF, 34);
        applyStimulus("divu_zero",  3'd5, 32'd100,       32'd0,         0, 32'hFFFF_FFFF, EARLY_LAT);
        applyStimulus("remu_zero",  3'd7, 32'd100,       32'd0,         0, 32'd100,       EARLY_LAT);
        applyStimulus("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 34);
        applyStimulus("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0,         34);
        applyStimulus("div_zero_s", 3'd4, 32'hFFFF_FFFB, 32'd0,         0, 32'hFFFF_FFFF, EARLY_LAT);
        applyStimulus("rem_zero_s", 3'd6, 32'hFFFF_FFFB, 32'd0,         0, 32'hFFFF_FFFB, EARLY_LAT);
        applyStimulus("rem_small",  3'd6, 32'hFFFF_FFFB, 32'd7,         0, 32'hFFFF_FFFB, EARLY_LAT);
        applyStimulus("divu_small", 3'd5, 32'd5,         32'd7,         0, 32'd0,         EARLY_LAT);
        applyStimulus("div_mix",    3'd4, 32'd100,       32'hFFFF_FFF9, 0, 32'hFFFF_FFF2, 34);
        applyStimulus("divu_hold",  3'd5, 32'hFFFF_FFFF, 32'd3,         5, 32'h5555_5555, 34);

        // Abort a divide part-way through its iteration.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        op       = 3'd4;
        rs1      = 32'd1000;
        rs2      = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("abort_in_ready", in_ready, 1);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_R", R, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn   = 1'b1;
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        checkOutput("abort_no_valid", spurious, 0);
        checkOutput("abort_ready", in_ready, 1);

        applyStimulus("mul_after",  3'd0, 32'd3,         32'd5,         0, 32'd15,        2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m_seq.md
# m_seq

Sequencer and operand/state register file for the M-extension unit. Accepts one MUL/DIV-class operation at a time from the execute stage and owns the R (remainder), D (divisor) and Z (quotient) registers. Drives the mux selects of the combinational M datapath and consumes its `sub_result`, `product`, `div_rem` and `div_rem_neg` outputs. Returns one 32-bit result per operation over a valid/ready handshake.

## Interface
- No parameters. Select widths and encodings come from `m_definitions.svh`.
- `clk` in 1: clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept a request. High only in IDLE.
- `op` in 3: funct3. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1`, `rs2` in 32 each: dividend/multiplicand and divisor/multiplier.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `result` out 32: operation result.
- `mux_multA`, `mux_multB`, `mux_div_rem` out (`MUX_*_LENGTH` each): datapath selects.
- `R` out 32, `D` out 63, `Z` out 32: state registers driven to the datapath.
- `sub_result` in 32, `product` in 64, `div_rem` in 32, `div_rem_neg` in 32: datapath returns.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- **IDLE**
  - Accept on `in_valid && in_ready`. Latch `op` and the sign flags.
  - MUL class: R←rs1, D←{rs2,31'b0}, go to MUL.
  - DIV class: R←|rs1|, D←{|rs2|,31'b0}, Z←0, counter←31, go to DIV. Absolute value applies only for DIV/REM; DIVU/REMU use raw operands.
- **MUL** (1 cycle)
  - `mux_multA` is SIGNED for MULH/MULHSU, otherwise UNSIGNED.
  - `mux_multB` is SIGNED for MULH only, otherwise UNSIGNED.
  - `result` latches `product[31:0]` for MUL, otherwise `product[63:32]`. Go to DONE.
- **DIV** (32 cycles)
  - fit = (D[62:32]==0) && (R ≥ D[31:0]), unsigned compare.
  - If fit, R←`sub_result`. In all cases Z←{Z[30:0],fit} and D←D>>1.
  - Go to FIX when counter==0, otherwise decrement the counter.
  - `mux_multA` and `mux_multB` are ZERO in every state except MUL.
- **FIX** (1 cycle)
  - `mux_div_rem` selects Z for DIV/DIVU, R for REM/REMU.
  - Negate the quotient (use `div_rem_neg`) iff signed and rs1[31]≠rs2[31] and rs2≠0.
  - Negate the remainder iff signed and rs1[31]. Otherwise use `div_rem`. Go to DONE.
- **DONE**
  - `out_valid`=1 and `result` is stable.
  - On `out_ready`, return to IDLE. If `out_ready` is low, hold the state and `result`.
- Divide by zero yields quotient 0xFFFFFFFF and remainder rs1 through the normal iteration.
- Overflow (−2³¹ / −1) yields quotient 0x80000000 and remainder 0 without a special case.

## Timing
- Reset values:
  - Outputs: `in_ready`=1, `out_valid`=0, `result`=0, R=0, D=0, Z=0.
  - Selects: `mux_multA`/`mux_multB` ZERO, `mux_div_rem` R.
  - State IDLE, counter 0.
- Accept at edge T.
  - MUL class: `out_valid` at T+2.
  - DIV class: `out_valid` at T+34. With `M_DIV_EARLY_OUT_EN` early-out, `out_valid` at T+1.
- `in_ready` is 0 from T+1 until the cycle after the DONE handshake. Back-to-back throughput is 1 operation per 3 cycles for MUL class.
- `resetn` low mid-operation aborts immediately to reset values, with no result emitted.
- `result` changes only on the transition into DONE.

## Configuration
- `M_DIV_EARLY_OUT_EN` defined: DIV-class requests whose latency is known at accept go directly to DONE with `result` loaded in the accept cycle.
  - Divisor 0 gives quotient 0xFFFFFFFF and remainder rs1.
  - Unsigned |rs1| < |rs2| gives quotient 0 and remainder rs1.
- Undefined: every DIV-class operation takes the full 34-cycle path, with identical results.

## Test plan
- MULHSU, rs1=0xFFFFFFFF, rs2=0x00000002 -> `result`=0xFFFFFFFF; `out_valid` exactly 2 cycles after accept.
- DIV, rs1=−7, rs2=2 -> `result`=0xFFFFFFFD (−3). REM on the same operands -> 0xFFFFFFFF (−1). `out_valid` at T+34.
- DIVU, rs1=100, rs2=0 -> 0xFFFFFFFF. REMU, rs1=100, rs2=0 -> 100. Latency T+1 with the macro defined, T+34 without.
- DIV, rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000. REM on the same operands -> 0.
- Hold `out_ready`=0 for 5 cycles in DONE -> `result`/`out_valid` stable and `in_ready`=0. Release -> IDLE next cycle.
- Assert `resetn` low at DIV iteration 10 -> all outputs at reset values while low, `in_ready`=1 after release, and no spurious `out_valid`.
